// File: rtl/svc_rv_pipe_stage.sv
// svc_rv_pipe_stage: generic pipeline stage register with valid/ready
// handshake and synchronous flush. It carries an opaque control bundle,
// which is cleared on reset and flush, and an opaque data bundle, which is
// never reset.
// MODE 0 = combinational passthrough, MODE 1 = single register,
// MODE 2 = two-entry skid buffer with a registered s_ready.
module svc_rv_pipe_stage #(
  parameter int                CTRL_W   = 8,
  parameter int                DATA_W   = 32,
  parameter int                MODE     = 1,
  parameter logic [CTRL_W-1:0] CTRL_CLR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [CTRL_W-1:0] s_ctrl,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [CTRL_W-1:0] m_ctrl,
  output logic [DATA_W-1:0] m_data,
  output logic [1:0]        occupancy
);

  generate
    if (MODE == 0) begin : g_pass
      // Pure wiring. A flush kills the input and also claims readiness, so
      // upstream sees the entry as consumed.
      logic pass_valid;

      assign pass_valid = s_valid && !flush;
      assign m_valid    = pass_valid;
      assign m_ctrl     = pass_valid ? s_ctrl : CTRL_CLR;
      assign m_data     = s_data;
      assign s_ready    = m_ready || flush;
      assign occupancy  = 2'd0;

    end else if (MODE == 1) begin : g_reg
      logic              m_valid_q;
      logic [CTRL_W-1:0] m_ctrl_q;
      logic [DATA_W-1:0] m_data_q;
      logic              s_ready_int;
      logic              accept;

      // The output register can take a new entry when it is empty or is
      // being drained in this same cycle.
      assign s_ready_int = !m_valid_q || m_ready;
      assign accept      = s_valid && s_ready_int;

      // Control and valid path: flush has priority, then a new accept, then
      // a drain that leaves the register empty.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          m_valid_q <= 1'b0;
          m_ctrl_q  <= CTRL_CLR;
        end else if (flush) begin
          m_valid_q <= 1'b0;
          m_ctrl_q  <= CTRL_CLR;
        end else if (accept) begin
          m_valid_q <= 1'b1;
          m_ctrl_q  <= s_ctrl;
        end else if (m_ready) begin
          m_valid_q <= 1'b0;
          m_ctrl_q  <= CTRL_CLR;
        end
      end

      // Data path is never reset; it follows every accept and holds otherwise.
      always_ff @(posedge clk) begin
        if (accept && !flush) begin
          m_data_q <= s_data;
        end
      end

      assign s_ready   = s_ready_int;
      assign m_valid   = m_valid_q;
      assign m_ctrl    = m_ctrl_q;
      assign m_data    = m_data_q;
      assign occupancy = {1'b0, m_valid_q};

    end else begin : g_skid
      // The state encoding equals the number of held entries.
      localparam logic [1:0] ST_EMPTY = 2'd0;
      localparam logic [1:0] ST_ONE   = 2'd1;
      localparam logic [1:0] ST_FULL  = 2'd2;

      logic [1:0]        state_q;
      logic [1:0]        state_d;
      logic              s_ready_q;
      logic [CTRL_W-1:0] m_ctrl_q;
      logic [DATA_W-1:0] m_data_q;
      logic [CTRL_W-1:0] skid_ctrl_q;
      logic [DATA_W-1:0] skid_data_q;
      logic              accept;
      logic              ld_m_from_s;
      logic              ld_m_from_skid;
      logic              ld_skid;
      logic              clr_m;

      // s_ready comes straight from a flop, so m_ready never reaches it
      // combinationally; the skid entry absorbs the one-cycle lag.
      assign accept = s_valid && s_ready_q;

      // Next-state decode and output-register load selects.
      always_comb begin
        state_d        = state_q;
        ld_m_from_s    = 1'b0;
        ld_m_from_skid = 1'b0;
        ld_skid        = 1'b0;
        clr_m          = 1'b0;
        if (flush) begin
          state_d = ST_EMPTY;
          clr_m   = 1'b1;
        end else begin
          case (state_q)
            ST_EMPTY: begin
              if (accept) begin
                state_d     = ST_ONE;
                ld_m_from_s = 1'b1;
              end
            end
            ST_ONE: begin
              if (accept && m_ready) begin
                ld_m_from_s = 1'b1;
              end else if (accept) begin
                state_d = ST_FULL;
                ld_skid = 1'b1;
              end else if (m_ready) begin
                state_d = ST_EMPTY;
                clr_m   = 1'b1;
              end
            end
            ST_FULL: begin
              if (m_ready) begin
                state_d        = ST_ONE;
                ld_m_from_skid = 1'b1;
              end
            end
            default: begin
              state_d = ST_EMPTY;
              clr_m   = 1'b1;
            end
          endcase
        end
      end

      // State, registered s_ready and output control bundle.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_q   <= ST_EMPTY;
          s_ready_q <= 1'b1;
          m_ctrl_q  <= CTRL_CLR;
        end else begin
          state_q   <= state_d;
          s_ready_q <= (state_d != ST_FULL);
          if (clr_m) begin
            m_ctrl_q <= CTRL_CLR;
          end else if (ld_m_from_s) begin
            m_ctrl_q <= s_ctrl;
          end else if (ld_m_from_skid) begin
            m_ctrl_q <= skid_ctrl_q;
          end
        end
      end

      // Unreset storage: the output data and the skid entry. The skid
      // control is only ever observed after it has been written.
      always_ff @(posedge clk) begin
        if (ld_m_from_s) begin
          m_data_q <= s_data;
        end else if (ld_m_from_skid) begin
          m_data_q <= skid_data_q;
        end
        if (ld_skid) begin
          skid_ctrl_q <= s_ctrl;
          skid_data_q <= s_data;
        end
      end

      assign s_ready   = s_ready_q;
      assign m_valid   = (state_q != ST_EMPTY);
      assign m_ctrl    = m_ctrl_q;
      assign m_data    = m_data_q;
      assign occupancy = state_q;
    end
  endgenerate

endmodule

// File: tb/tb_svc_rv_pipe_stage.sv
// Directed testbench for svc_rv_pipe_stage. It instantiates one stage for
// each mode, each with its own stimulus, and checks them with immediate
// assertions.
module tb_svc_rv_pipe_stage;
  localparam int          CW  = 8;
  localparam int          DW  = 32;
  localparam logic [7:0]  CLR = 8'hC3;

  logic clk;
  logic rst_n;

  // Stimulus and observation signals, one set per mode
  logic          flush0, s_valid0, s_ready0, m_valid0, m_ready0;
  logic [CW-1:0] s_ctrl0, m_ctrl0;
  logic [DW-1:0] s_data0, m_data0;
  logic [1:0]    occ0;
  logic          flush1, s_valid1, s_ready1, m_valid1, m_ready1;
  logic [CW-1:0] s_ctrl1, m_ctrl1;
  logic [DW-1:0] s_data1, m_data1;
  logic [1:0]    occ1;
  logic          flush2, s_valid2, s_ready2, m_valid2, m_ready2;
  logic [CW-1:0] s_ctrl2, m_ctrl2;
  logic [DW-1:0] s_data2, m_data2;
  logic [1:0]    occ2;

  int passed = 0;
  int total  = 0;

  svc_rv_pipe_stage #(.CTRL_W(CW), .DATA_W(DW), .MODE(0), .CTRL_CLR(CLR)) u_m0 (
    .clk(clk), .rst_n(rst_n), .flush(flush0),
    .s_valid(s_valid0), .s_ready(s_ready0), .s_ctrl(s_ctrl0), .s_data(s_data0),
    .m_valid(m_valid0), .m_ready(m_ready0), .m_ctrl(m_ctrl0), .m_data(m_data0),
    .occupancy(occ0));

  svc_rv_pipe_stage #(.CTRL_W(CW), .DATA_W(DW), .MODE(1), .CTRL_CLR(CLR)) u_m1 (
    .clk(clk), .rst_n(rst_n), .flush(flush1),
    .s_valid(s_valid1), .s_ready(s_ready1), .s_ctrl(s_ctrl1), .s_data(s_data1),
    .m_valid(m_valid1), .m_ready(m_ready1), .m_ctrl(m_ctrl1), .m_data(m_data1),
    .occupancy(occ1));

  svc_rv_pipe_stage #(.CTRL_W(CW), .DATA_W(DW), .MODE(2), .CTRL_CLR(CLR)) u_m2 (
    .clk(clk), .rst_n(rst_n), .flush(flush2),
    .s_valid(s_valid2), .s_ready(s_ready2), .s_ctrl(s_ctrl2), .s_data(s_data2),
    .m_valid(m_valid2), .m_ready(m_ready2), .m_ctrl(m_ctrl2), .m_data(m_data2),
    .occupancy(occ2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    flush0 = 0; s_valid0 = 0; m_ready0 = 0; s_ctrl0 = 0; s_data0 = 0;
    flush1 = 0; s_valid1 = 0; m_ready1 = 0; s_ctrl1 = 0; s_data1 = 0;
    flush2 = 0; s_valid2 = 0; m_ready2 = 0; s_ctrl2 = 0; s_data2 = 0;

    // Reset state
    #12;
    chk("rst_m1_valid", m_valid1, 0);
    chk("rst_m1_ctrl", m_ctrl1, CLR);
    chk("rst_m1_occ", occ1, 0);
    chk("rst_m1_sready", s_ready1, 1);
    chk("rst_m2_valid", m_valid2, 0);
    chk("rst_m2_ctrl", m_ctrl2, CLR);
    chk("rst_m2_occ", occ2, 0);
    chk("rst_m2_sready", s_ready2, 1);
    #6 rst_n = 1'b1;
    tick();

    // MODE 0: combinational passthrough and flush override
    s_valid0 = 1; s_ctrl0 = 8'h5A; s_data0 = 32'hDEAD_0001; m_ready0 = 0;
    #1;
    $display("m0 pass ctrl=%0h sready=%0b", m_ctrl0, s_ready0);
    chk("m0_ctrl", m_ctrl0, 8'h5A);
    chk("m0_valid", m_valid0, 1);
    chk("m0_data", m_data0, 32'hDEAD_0001);
    chk("m0_sready_lo", s_ready0, 0);
    chk("m0_occ", occ0, 0);
    m_ready0 = 1; #1;
    chk("m0_sready_hi", s_ready0, 1);
    m_ready0 = 0; flush0 = 1; #1;
    $display("m0 flush valid=%0b ctrl=%0h", m_valid0, m_ctrl0);
    chk("m0_flush_valid", m_valid0, 0);
    chk("m0_flush_ctrl", m_ctrl0, CLR);
    chk("m0_flush_sready", s_ready0, 1);
    flush0 = 0; s_valid0 = 0;

    // MODE 1: accept together with flush is dropped
    s_valid1 = 1; s_ctrl1 = 8'h55; s_data1 = 32'h55; m_ready1 = 1; flush1 = 1;
    #1 chk("m1_flush_sready", s_ready1, 1);
    tick();
    flush1 = 0; s_valid1 = 0; #1;
    $display("m1 accept+flush valid=%0b", m_valid1);
    chk("m1_flush_valid", m_valid1, 0);
    chk("m1_flush_ctrl", m_ctrl1, CLR);

    // MODE 1: back-to-back full throughput
    s_valid1 = 1; m_ready1 = 1;
    for (int i = 0; i < 4; i++) begin
      s_ctrl1 = 8'(8'h10 + i);
      s_data1 = 32'h100 + 32'(i);
      tick();
      $display("m1 stream %0d data=%0h", i, m_data1);
      chk("m1_stream_valid", m_valid1, 1);
      chk("m1_stream_data", m_data1, 64'h100 + 64'(i));
      chk("m1_stream_ctrl", m_ctrl1, 64'h10 + 64'(i));
      chk("m1_stream_sready", s_ready1, 1);
    end
    // Backpressure: s_ready drops in the same cycle as m_ready
    m_ready1 = 0; s_ctrl1 = 8'h77; s_data1 = 32'h777; #1;
    chk("m1_sready_comb", s_ready1, 0);
    tick();
    $display("m1 stall data=%0h", m_data1);
    chk("m1_stall_data", m_data1, 32'h103);
    chk("m1_stall_ctrl", m_ctrl1, 8'h13);
    chk("m1_stall_occ", occ1, 1);
    s_valid1 = 0; m_ready1 = 1; #1;
    chk("m1_sready_back", s_ready1, 1);
    tick();
    chk("m1_drain_valid", m_valid1, 0);
    chk("m1_drain_ctrl", m_ctrl1, CLR);
    chk("m1_drain_occ", occ1, 0);

    // MODE 2: streaming at one-cycle latency
    s_valid2 = 1; m_ready2 = 1;
    for (int i = 1; i <= 4; i++) begin
      s_ctrl2 = 8'(i);
      s_data2 = 32'(i);
      tick();
      $display("m2 stream data=%0h occ=%0d", m_data2, occ2);
      chk("m2_stream_data", m_data2, 64'(i));
      chk("m2_stream_ctrl", m_ctrl2, 64'(i));
      chk("m2_stream_occ", occ2, 1);
      chk("m2_stream_sready", s_ready2, 1);
    end
    s_valid2 = 0; tick();
    chk("m2_stream_end_valid", m_valid2, 0);
    chk("m2_stream_end_ctrl", m_ctrl2, CLR);
    chk("m2_stream_end_occ", occ2, 0);

    // MODE 2: fill the skid, then drain in order
    m_ready2 = 0; s_valid2 = 1; s_ctrl2 = 8'h0A; s_data2 = 32'hA; tick();
    chk("m2_fill1_occ", occ2, 1);
    s_ctrl2 = 8'h0B; s_data2 = 32'hB; tick();
    s_valid2 = 0;
    $display("m2 full occ=%0d sready=%0b data=%0h", occ2, s_ready2, m_data2);
    chk("m2_full_occ", occ2, 2);
    chk("m2_full_sready", s_ready2, 0);
    chk("m2_full_data", m_data2, 32'hA);
    tick();
    chk("m2_hold_data", m_data2, 32'hA);
    chk("m2_hold_ctrl", m_ctrl2, 8'h0A);
    m_ready2 = 1; tick();
    $display("m2 drain data=%0h occ=%0d", m_data2, occ2);
    chk("m2_drain_data", m_data2, 32'hB);
    chk("m2_drain_ctrl", m_ctrl2, 8'h0B);
    chk("m2_drain_occ", occ2, 1);
    chk("m2_drain_sready", s_ready2, 1);
    tick();
    chk("m2_empty_occ", occ2, 0);
    chk("m2_empty_valid", m_valid2, 0);

    // MODE 2: flush while full drops both entries
    m_ready2 = 0; s_valid2 = 1; s_ctrl2 = 8'h21; s_data2 = 32'h21; tick();
    s_ctrl2 = 8'h22; s_data2 = 32'h22; tick();
    chk("m2_prefl_occ", occ2, 2);
    s_valid2 = 0; m_ready2 = 1; flush2 = 1; tick();
    flush2 = 0;
    $display("m2 flush valid=%0b occ=%0d", m_valid2, occ2);
    chk("m2_fl_valid", m_valid2, 0);
    chk("m2_fl_ctrl", m_ctrl2, CLR);
    chk("m2_fl_occ", occ2, 0);
    chk("m2_fl_sready", s_ready2, 1);
    tick();
    chk("m2_fl_stay_valid", m_valid2, 0);

    // MODE 2: asynchronous reset between edges while full
    m_ready2 = 0; s_valid2 = 1; s_ctrl2 = 8'h31; s_data2 = 32'h31; tick();
    s_ctrl2 = 8'h32; s_data2 = 32'h32; tick();
    s_valid2 = 0;
    chk("m2_prerst_occ", occ2, 2);
    @(negedge clk); #2;
    rst_n = 1'b0; #1;
    $display("m2 async reset valid=%0b occ=%0d", m_valid2, occ2);
    chk("m2_arst_valid", m_valid2, 0);
    chk("m2_arst_ctrl", m_ctrl2, CLR);
    chk("m2_arst_occ", occ2, 0);
    chk("m2_arst_sready", s_ready2, 1);
    #1 rst_n = 1'b1;
    m_ready2 = 1; tick();
    chk("m2_post_rst_valid", m_valid2, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/svc_rv_pipe_stage.md
Name: svc_rv_pipe_stage

Overview:
- Generic parametrised RISC-V pipeline stage register with a valid/ready handshake, synchronous flush, and a selectable implementation mode: passthrough, single register, or 2-entry skid buffer.
- Successor to the fixed-field stage registers; carries one opaque control bundle (reset and flush cleared) and one opaque data bundle (never reset) between any two pipeline stages.
- Replaces the stall input with per-stage backpressure.

Parameters:
- CTRL_W, 8, width of control bundle; cleared on reset and flush.
- DATA_W, 32, width of data bundle; not reset, not cleared.
- MODE, 1, 0 = combinational passthrough, 1 = single register, 2 = skid buffer (registered s_ready).
- CTRL_CLR, '0, value loaded into m_ctrl on reset and flush (CTRL_W bits).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous kill of all held entries and of the current input
- s_valid  in  1  upstream entry valid
- s_ready  out  1  stage can accept
- s_ctrl  in  CTRL_W  upstream control bundle
- s_data  in  DATA_W  upstream data bundle
- m_valid  out  1  downstream entry valid
- m_ready  in  1  downstream accepts
- m_ctrl  out  CTRL_W  downstream control bundle
- m_data  out  DATA_W  downstream data bundle
- occupancy  out  2  entries held (0..2); always 0 in MODE 0

Behaviour:
- Transfer occurs on a clk edge where valid && ready on that side. No entry is lost or duplicated except by flush.
- Async reset (any mode ≥ 1): m_valid=0, m_ctrl=CTRL_CLR, occupancy=0, skid entry empty. s_ready=1 in MODE 1 when m_valid=0, and in MODE 2. m_data and skid data are not reset.
- MODE 0:
  - m_* = s_*, s_ready = m_ready.
  - flush forces m_valid=0, m_ctrl=CTRL_CLR, s_ready=1; the input is dropped.
  - occupancy=0; clk and rst_n are unused.
- MODE 1:
  - s_ready = !m_valid || m_ready (combinational from m_ready).
  - On an accept, load m_* from s_* with 1-cycle latency.
  - If m_ready && !accept, then m_valid<=0 and m_ctrl<=CTRL_CLR.
  - Hold otherwise.
- MODE 2: states EMPTY (occ 0), ONE (occ 1), FULL (occ 2, skid holds the younger entry). s_ready is registered (= state != FULL); no combinational path from m_ready to s_ready.
  - EMPTY + accept -> ONE, m_* <= s_*.
  - ONE + accept + m_ready -> ONE, m_* <= s_*.
  - ONE + accept + !m_ready -> FULL, skid <= s_*.
  - ONE + !accept + m_ready -> EMPTY, m_ctrl <= CTRL_CLR.
  - FULL + m_ready -> ONE, m_* <= skid. No accept is possible because s_ready=0.
  - FULL + !m_ready -> FULL, hold.
  - Order is strictly FIFO.
- Flush (MODES 1 and 2):
  - Dominates every other event in the same cycle, including a simultaneous accept and a simultaneous downstream transfer.
  - Next state: EMPTY, m_valid=0, m_ctrl=CTRL_CLR, occupancy=0, s_ready=1.
  - The upstream handshake during the flush cycle is considered consumed and the entry is discarded.
- While m_valid=0: m_ctrl=CTRL_CLR. m_data is don't-care and must not be checked.
- m_ctrl and m_data are stable while m_valid && !m_ready.
- Reset asserted mid-transfer: all held entries are dropped immediately and asynchronously.

Test Plan:
- MODE 2, m_ready=1, s_valid=1 streaming s_data=1,2,3,4 -> m_data 1,2,3,4 on consecutive cycles at 1-cycle latency, occupancy=1, s_ready=1 throughout.
- MODE 2: send 0xA then 0xB with m_ready=0 -> occupancy=2, s_ready=0, m_data=0xA held. Raise m_ready -> 0xA then 0xB delivered in order, then occupancy=0.
- MODE 2, FULL, assert flush with m_ready=1 -> next cycle m_valid=0, m_ctrl=CTRL_CLR, occupancy=0, s_ready=1. Neither held entry appears on the output.
- MODE 1: accept with flush asserted in the same cycle -> m_valid stays 0. Back-to-back with m_ready=1 -> full throughput. m_ready=0 -> s_ready=0 combinationally.
- Drop rst_n asynchronously between clk edges while occupancy=2 -> m_valid=0, m_ctrl=CTRL_CLR, occupancy=0 immediately, without waiting for a clock edge.
- MODE 0, s_valid=1, s_ctrl=0x5A, m_ready=0 -> m_ctrl=0x5A and s_ready=0 in the same cycle. Assert flush -> m_valid=0, m_ctrl=CTRL_CLR, s_ready=1.
